reflet_mmio_fifo: RTL and testbench
===================================

Name: reflet_mmio_fifo

Overview:
Memory-mapped bus responder for the reflet CPU data bus. The CPU writes words into a transmit FIFO and polls status and count registers. An external consumer drains the FIFO through a valid/ready stream. The block sits beside ROM and RAM on the shared OR-combined read bus, selected by an address-decode `enable`.

Parameters:
wordsize, 8, bus and FIFO data width in bits (must be >= DEPTH_LOG2+1)
DEPTH_LOG2, 3, log2 of FIFO depth (default depth 8)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  chip select from the address decoder
addr  input  2  register select: 0 DATA, 1 STATUS, 2 COUNT, 3 CTRL
data_in  input  wordsize  CPU write data
write_en  input  1  CPU write strobe, qualified by enable
data_out  output  wordsize  registered read data; all-zero when not selected (OR bus)
out_data  output  wordsize  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Reset (async, active-high): pointers 0, count 0, overflow 0, data_out 0, out_valid 0. Storage contents are don't-care.
- Bus write (enable & write_en), decoded by addr:
  - DATA: push data_in.
  - CTRL: bit0=1 flushes the FIFO (pointers and count to 0); bit1=1 clears overflow. Other bits are ignored.
  - STATUS and COUNT: writes are ignored.
- Bus read: data_out is registered with 1-cycle latency.
  - At posedge with enable & !write_en, data_out loads the addressed register. Otherwise data_out loads 0.
  - DATA reads 0.
  - STATUS reads bit0 empty, bit1 full, bit2 overflow, other bits 0.
  - COUNT reads count, zero-extended to wordsize.
  - CTRL reads 0.
  - Reads return the pre-edge state.
- Stream side:
  - out_valid = (count != 0), combinational from registers.
  - out_data = storage[rd_ptr].
  - Pop occurs when out_valid & out_ready at posedge.
- Push and full conditions:
  - "full" means count == 2^DEPTH_LOG2, evaluated before the edge.
  - A push is accepted if !full, or if full with a simultaneous pop. In that case the count is unchanged and both pointers advance.
  - A push while full without a pop is dropped and sets overflow (sticky until cleared via CTRL bit1).
- Simultaneous push and pop when not empty: count is unchanged.
- Pop on empty is impossible, because out_valid is low.
- Flush has priority over a same-cycle push or pop: both are discarded and count becomes 0. Clear-overflow and flush may be requested together.
- If an overflow event and a clear-overflow write occur in the same cycle, set wins (overflow stays 1).
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. count is DEPTH_LOG2+1 bits.
- Reset asserted mid-stream clears everything immediately. out_valid drops asynchronously.

Decomposition:
- Shared package reflet_mmio_pkg:
  - register address constants REG_DATA=0, REG_STATUS=1, REG_COUNT=2, REG_CTRL=3
  - status bit indices ST_EMPTY=0, ST_FULL=1, ST_OVF=2
  - ctrl bit indices CTL_FLUSH=0, CTL_CLROVF=1
- One sub-module, reflet_fifo_core, holds storage, pointers, count, push/pop/flush and full/empty.
- The top level contains the bus decode, overflow flag and data_out register.

Test Plan:
- Reset, then read STATUS and COUNT with enable=1 -> data_out = 0x01 then 0x00 one cycle after each address. out_valid=0.
- Write 0xA5, 0x3C to DATA, out_ready=0 -> COUNT reads 0x02, out_valid=1, out_data=0xA5. Raise out_ready for 2 cycles -> 0xA5 then 0x3C consumed, STATUS=0x01.
- Write 8 words 0x10..0x17, then a 9th word 0xFF with out_ready=0 -> STATUS=0x06 (full+ovf), COUNT=0x08. Drain yields 0x10..0x17 in order; 0xFF never appears.
- With the FIFO full and out_ready=1, write 0x99 in the same cycle as the pop -> accepted, count stays 8, overflow stays 0. 0x99 emerges last.
- With 3 words queued, write CTRL=0x03 while out_ready=1 -> next cycle COUNT=0, overflow=0, out_valid=0, and no word is popped that cycle. Repeat after wrapping the pointers past depth to check wrap-around.
- With enable=0 and addr=1 -> data_out stays 0x00. Assert reset mid-drain -> out_valid and data_out go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reflet_mmio_pkg.sv
// reflet_mmio_pkg
//   Shared constants for the reflet memory-mapped FIFO responder:
//   register addresses, STATUS bit positions and CTRL bit positions.
package reflet_mmio_pkg;

  // Register map (2-bit word address inside the block)
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS register bit positions
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  // CTRL register bit positions
  localparam int CTL_FLUSH  = 0;
  localparam int CTL_CLROVF = 1;

endpackage

// File: rtl/reflet_fifo_core.sv
// reflet_fifo_core
//   Circular-buffer FIFO with occupancy counter, used by reflet_mmio_fifo.
//   Ports:
//     clk        system clock, rising edge
//     reset      asynchronous active-high reset (pointers and count)
//     push       request to write push_data (dropped while full unless popping)
//     pop        request to remove the head word (ignored while empty)
//     flush      empties the FIFO; discards a same-cycle push and pop
//     push_data  word to store
//     head_data  current head word (storage at the read pointer)
//     count      number of stored words, 0 .. 2**DEPTH_LOG2
//     full       count == 2**DEPTH_LOG2
//     empty      count == 0
module reflet_fifo_core #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      push_data,
  output logic [WIDTH-1:0]      head_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic w_pop;
  logic w_push;

  assign full  = (r_count == FULL_COUNT);
  assign empty = (r_count == '0);
  assign count = r_count;

  // A pop frees a slot in the same edge, so a push while full is still
  // accepted when it coincides with a pop. Flush overrides both.
  assign w_pop  = pop & ~empty & ~flush;
  assign w_push = push & (~full | w_pop) & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; only valid entries are ever observed.
  // When full with a simultaneous pop, wr_ptr == rd_ptr: the head word is
  // read combinationally before the edge, so overwriting the slot is safe.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/reflet_mmio_fifo.sv
// reflet_mmio_fifo
//   Memory-mapped transmit FIFO for the reflet CPU data bus. The CPU pushes
//   words through DATA, polls STATUS/COUNT and flushes/clears via CTRL; an
//   external consumer drains the FIFO over a valid/ready stream.
//   Ports:
//     clk        system clock, rising edge
//     reset      asynchronous active-high reset
//     enable     chip select from the address decoder
//     addr       register select: 0 DATA, 1 STATUS, 2 COUNT, 3 CTRL
//     data_in    CPU write data
//     write_en   CPU write strobe (qualified by enable)
//     data_out   registered read data, zero when not selected (OR bus)
//     out_data   FIFO head word
//     out_valid  FIFO non-empty
//     out_ready  consumer accepts out_data this cycle
module reflet_mmio_fifo
  import reflet_mmio_pkg::*;
#(
  parameter int wordsize   = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic [wordsize-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  logic                r_ovf;
  logic [wordsize-1:0] r_data_out;

  logic                w_bus_wr;
  logic                w_bus_rd;
  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_clr_ovf;
  logic                w_ovf_event;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_full;
  logic                w_empty;
  logic [wordsize-1:0] w_status;
  logic [wordsize-1:0] w_count_ext;
  logic [wordsize-1:0] w_rd_value;

  assign w_bus_wr  = enable & write_en;
  assign w_bus_rd  = enable & ~write_en;
  assign w_push    = w_bus_wr & (addr == REG_DATA);
  assign w_flush   = w_bus_wr & (addr == REG_CTRL) & data_in[CTL_FLUSH];
  assign w_clr_ovf = w_bus_wr & (addr == REG_CTRL) & data_in[CTL_CLROVF];
  assign w_pop     = out_ready & ~w_empty;

  // A push is lost only when full with no pop to make room; a flush in the
  // same cycle discards the push outright, so it is not an overflow.
  assign w_ovf_event = w_push & w_full & ~w_pop & ~w_flush;

  reflet_fifo_core #(
    .WIDTH      (wordsize),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .flush     (w_flush),
    .push_data (data_in),
    .head_data (out_data),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign out_valid = ~w_empty;

  // Sticky overflow; a new overflow beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_event) begin
      r_ovf <= 1'b1;
    end else if (w_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_status           = '0;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_OVF]   = r_ovf;
  end

  always_comb begin
    w_count_ext               = '0;
    w_count_ext[DEPTH_LOG2:0] = w_count;
  end

  always_comb begin
    w_rd_value = '0;
    case (addr)
      REG_STATUS: w_rd_value = w_status;
      REG_COUNT:  w_rd_value = w_count_ext;
      default:    w_rd_value = '0;
    endcase
  end

  // Read data is zero whenever this block is not being read, so it can be
  // OR-combined with the other bus responders.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= '0;
    end else if (w_bus_rd) begin
      r_data_out <= w_rd_value;
    end else begin
      r_data_out <= '0;
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_reflet_mmio_fifo.sv
module tb_reflet_mmio_fifo;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic       write_en;
  logic [7:0] data_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int checks;
  int errors;

  reflet_mmio_fifo #(
    .wordsize   (8),
    .DEPTH_LOG2 (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .addr      (addr),
    .data_in   (data_in),
    .write_en  (write_en),
    .data_out  (data_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Posedges at 5, 15, 25 ...; inputs change and outputs are sampled on negedges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Bus helpers (stimulus only; comparisons are done in the test tasks).
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    enable = 1'b1; write_en = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0; data_in = 8'h00;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk);
    enable = 1'b1; write_en = 1'b0; addr = a;
    @(negedge clk);
    v = data_out;
    enable = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL reset_data_out: got %h expected 00", data_out);
    end
    bus_read(2'd1, v);
    checks++;
    if (v !== 8'h01) begin
      errors++; $display("FAIL reset_status: got %h expected 01", v);
    end
    bus_read(2'd2, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL reset_count: got %h expected 00", v);
    end
    $display("test_reset: status/count read after reset done");
  endtask

  task automatic test_basic;
    logic [7:0] v;
    out_ready = 1'b0;
    bus_write(2'd0, 8'hA5);
    bus_write(2'd0, 8'h3C);
    bus_read(2'd2, v);
    checks++;
    if (v !== 8'h02) begin
      errors++; $display("FAIL basic_count: got %h expected 02", v);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++; $display("FAIL basic_head: got valid=%b data=%h expected valid=1 data=a5", out_valid, out_data);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
      errors++; $display("FAIL basic_second: got valid=%b data=%h expected valid=1 data=3c", out_valid, out_data);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drained: got valid=%b expected 0", out_valid);
    end
    bus_read(2'd1, v);
    checks++;
    if (v !== 8'h01) begin
      errors++; $display("FAIL basic_status: got %h expected 01", v);
    end
    $display("test_basic: push a5,3c and drain done");
  endtask

  task automatic test_overflow;
    logic [7:0] v;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(2'd0, 8'h10 + 8'(i));
    bus_write(2'd0, 8'hFF);
    bus_read(2'd1, v);
    checks++;
    if (v !== 8'h06) begin
      errors++; $display("FAIL ovf_status: got %h expected 06", v);
    end
    bus_read(2'd2, v);
    checks++;
    if (v !== 8'h08) begin
      errors++; $display("FAIL ovf_count: got %h expected 08", v);
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL ovf_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, 8'h10 + 8'(i));
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_dropped: got valid=%b data=%h expected valid=0", out_valid, out_data);
    end
    bus_write(2'd3, 8'h02);
    bus_read(2'd1, v);
    checks++;
    if (v !== 8'h01) begin
      errors++; $display("FAIL ovf_clear: got %h expected 01", v);
    end
    $display("test_overflow: fill 8, drop 9th, drain, clear done");
  endtask

  task automatic test_full_pushpop;
    logic [7:0] v;
    logic [7:0] exp;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(2'd0, 8'h20 + 8'(i));
    @(negedge clk);
    enable = 1'b1; write_en = 1'b1; addr = 2'd0; data_in = 8'h99; out_ready = 1'b1;
    checks++;
    if (out_data !== 8'h20) begin
      errors++; $display("FAIL fpp_head: got %h expected 20", out_data);
    end
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0; out_ready = 1'b0;
    bus_read(2'd2, v);
    checks++;
    if (v !== 8'h08) begin
      errors++; $display("FAIL fpp_count: got %h expected 08", v);
    end
    bus_read(2'd1, v);
    checks++;
    if (v !== 8'h02) begin
      errors++; $display("FAIL fpp_status: got %h expected 02", v);
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? 8'h99 : 8'h21 + 8'(i);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL fpp_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, exp);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL fpp_empty: got valid=%b expected 0", out_valid);
    end
    $display("test_full_pushpop: push on full with pop done");
  endtask

  task automatic test_flush;
    logic [7:0] v;
    out_ready = 1'b0;
    bus_write(2'd0, 8'h31);
    bus_write(2'd0, 8'h32);
    bus_write(2'd0, 8'h33);
    @(negedge clk);
    enable = 1'b1; write_en = 1'b1; addr = 2'd3; data_in = 8'h03; out_ready = 1'b1;
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_valid: got %b expected 0", out_valid);
    end
    bus_read(2'd2, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL flush_count: got %h expected 00", v);
    end
    bus_write(2'd0, 8'h44);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h44) begin
      errors++; $display("FAIL flush_newhead: got valid=%b data=%h expected valid=1 data=44", out_valid, out_data);
    end
    // Drain 0x44 so the pointers start at 1, then fill past the wrap point.
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(2'd0, 8'h60 + 8'(i));
    bus_write(2'd0, 8'h68);
    bus_read(2'd1, v);
    checks++;
    if (v !== 8'h06) begin
      errors++; $display("FAIL wrap_status: got %h expected 06", v);
    end
    @(negedge clk);
    enable = 1'b1; write_en = 1'b1; addr = 2'd3; data_in = 8'h03; out_ready = 1'b1;
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_flush_valid: got %b expected 0", out_valid);
    end
    bus_read(2'd1, v);
    checks++;
    if (v !== 8'h01) begin
      errors++; $display("FAIL wrap_flush_status: got %h expected 01", v);
    end
    bus_write(2'd0, 8'h77);
    checks++;
    if (out_data !== 8'h77) begin
      errors++; $display("FAIL wrap_flush_newhead: got %h expected 77", out_data);
    end
    bus_read(2'd2, v);
    checks++;
    if (v !== 8'h01) begin
      errors++; $display("FAIL wrap_flush_count: got %h expected 01", v);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("test_flush: flush+clear, wrap-around flush done");
  endtask

  task automatic test_bus_ignored;
    logic [7:0] v;
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0; addr = 2'd1;
    @(negedge clk);
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL disabled_read: got %h expected 00", data_out);
    end
    @(negedge clk);
    enable = 1'b1; write_en = 1'b1; addr = 2'd2; data_in = 8'h05;
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0;
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL write_cycle_data_out: got %h expected 00", data_out);
    end
    bus_read(2'd2, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL count_write_ignored: got %h expected 00", v);
    end
    bus_read(2'd0, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL data_reads_zero: got %h expected 00", v);
    end
    $display("test_bus_ignored: disabled read and ignored writes done");
  endtask

  task automatic test_async_reset;
    logic [7:0] v;
    out_ready = 1'b0;
    bus_write(2'd0, 8'h51);
    bus_write(2'd0, 8'h52);
    bus_write(2'd0, 8'h53);
    @(negedge clk);
    enable = 1'b1; write_en = 1'b0; addr = 2'd2; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (data_out !== 8'h03 || out_valid !== 1'b1 || out_data !== 8'h52) begin
      errors++; $display("FAIL midstream: got data_out=%h valid=%b data=%h expected 03/1/52", data_out, out_valid, out_data);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL async_reset: got valid=%b data_out=%h expected 0/00", out_valid, data_out);
    end
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; out_ready = 1'b0;
    bus_read(2'd2, v);
    checks++;
    if (v !== 8'h00) begin
      errors++; $display("FAIL post_reset_count: got %h expected 00", v);
    end
    $display("test_async_reset: mid-drain reset done");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    addr      = 2'd0;
    data_in   = 8'h00;
    write_en  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_flush();
    test_bus_ignored();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
